// File: rtl/scsdpram_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO built on a simple-dual-port RAM.
// The RAM output register is the head-of-queue slot, so total capacity is
// C_DEPTH+1 words. A RAM slot is freed when its read is issued, because the
// data then lives in the RAM output register until the consumer takes it.

// Single-clock simple-dual-port RAM: one write port, one registered read port.
module scsdpram #(
  parameter int C_WIDTH = 32,
  parameter int C_DEPTH = 1024,
  parameter int C_AW    = $clog2(C_DEPTH)
) (
  input  logic               CLK,
  input  logic               WR1_EN,
  input  logic [C_AW-1:0]    WR1_ADDR,
  input  logic [C_WIDTH-1:0] WR1_DATA,
  input  logic               RD1_EN,
  input  logic [C_AW-1:0]    RD1_ADDR,
  output logic [C_WIDTH-1:0] RD1_DATA
);
  logic [C_WIDTH-1:0] mem [C_DEPTH];

  // write port
  always_ff @(posedge CLK) begin
    if (WR1_EN) mem[WR1_ADDR] <= WR1_DATA;
  end

  // registered read; output holds when RD1_EN is low
  always_ff @(posedge CLK) begin
    if (RD1_EN) RD1_DATA <= mem[RD1_ADDR];
  end
endmodule

module scsdpram_fwft_fifo #(
  parameter int C_WIDTH = 32,
  parameter int C_DEPTH = 1024
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        WR_VALID,
  input  logic [C_WIDTH-1:0]          WR_DATA,
  output logic                        WR_READY,
  output logic                        RD_VALID,
  output logic [C_WIDTH-1:0]          RD_DATA,
  input  logic                        RD_READY,
  output logic [$clog2(C_DEPTH):0]    COUNT
);
  localparam int AW = $clog2(C_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(C_DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] mem_count, mem_count_nxt;
  logic          wr_ready_q, rd_valid_q;
  logic          wr_acc, rd_issue;

  // Reads only target slots committed at an earlier edge, and a write to
  // rd_ptr implies an empty RAM (no issue), so the ports never collide.
  assign wr_acc   = WR_VALID && wr_ready_q;
  assign rd_issue = (mem_count != '0) && (!rd_valid_q || RD_READY);

  scsdpram #(.C_WIDTH(C_WIDTH), .C_DEPTH(C_DEPTH), .C_AW(AW)) u_ram (
    .CLK      (CLK),
    .WR1_EN   (wr_acc),
    .WR1_ADDR (wr_ptr),
    .WR1_DATA (WR_DATA),
    .RD1_EN   (rd_issue),
    .RD1_ADDR (rd_ptr),
    .RD1_DATA (RD_DATA)
  );

  // RAM occupancy after this edge; simultaneous accept+issue cancels out
  always_comb begin
    mem_count_nxt = mem_count;
    case ({wr_acc, rd_issue})
      2'b10:   mem_count_nxt = mem_count + CW'(1);
      2'b01:   mem_count_nxt = mem_count - CW'(1);
      default: mem_count_nxt = mem_count;
    endcase
  end

  // pointers, occupancy and handshake flags; ready is registered from the
  // next occupancy so RD_READY has no combinational path to WR_READY
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_count  <= '0;
      wr_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_acc)   wr_ptr <= wr_ptr + AW'(1);
      if (rd_issue) rd_ptr <= rd_ptr + AW'(1);
      mem_count  <= mem_count_nxt;
      wr_ready_q <= (mem_count_nxt != FULL_CNT);
      rd_valid_q <= rd_issue | (rd_valid_q & !RD_READY);
    end
  end

  assign WR_READY = wr_ready_q;
  assign RD_VALID = rd_valid_q;
  assign COUNT    = mem_count + CW'(rd_valid_q);
endmodule

// File: tb/tb_scsdpram_fwft_fifo.sv
// Bench for scsdpram_fwft_fifo: directed checks on a depth-4 instance and
// randomized backpressure on a depth-8 instance, with a queue scoreboard
// monitor per instance that checks order, COUNT and output stability.
module tb_scsdpram_fwft_fifo;
  logic            CLK;
  logic [1:0]      rst_n, wv, rr, wrdy, rv;
  logic [1:0][31:0] wd, rd;
  logic [2:0]      cnt0;
  logic [3:0]      cnt1;
  logic [1:0][4:0] cnt;

  int n_chk = 0, n_fail = 0;
  logic [31:0] q0[$], q1[$];
  bit          hold[2];
  logic [31:0] hold_d[2];
  int          pops[2];

  assign cnt[0] = {2'b00, cnt0};
  assign cnt[1] = {1'b0, cnt1};

  scsdpram_fwft_fifo #(.C_WIDTH(32), .C_DEPTH(4)) dut4 (
    .CLK(CLK), .RST_N(rst_n[0]), .WR_VALID(wv[0]), .WR_DATA(wd[0]),
    .WR_READY(wrdy[0]), .RD_VALID(rv[0]), .RD_DATA(rd[0]),
    .RD_READY(rr[0]), .COUNT(cnt0));

  scsdpram_fwft_fifo #(.C_WIDTH(32), .C_DEPTH(8)) dut8 (
    .CLK(CLK), .RST_N(rst_n[1]), .WR_VALID(wv[1]), .WR_DATA(wd[1]),
    .WR_READY(wrdy[1]), .RD_VALID(rv[1]), .RD_DATA(rd[1]),
    .RD_READY(rr[1]), .COUNT(cnt1));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, got, exp, $time);
    end
  endfunction

  function automatic int dep(int i);
    return (i == 0) ? 4 : 8;
  endfunction

  function automatic int q_size(int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void q_push(int i, logic [31:0] v);
    if (i == 0) q0.push_back(v); else q1.push_back(v);
  endfunction

  function automatic logic [31:0] q_pop(int i);
    if (i == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic void q_clear(int i);
    if (i == 0) q0.delete(); else q1.delete();
    hold[i] = 1'b0;
  endfunction

  // Scoreboard monitor: samples on the falling edge, where inputs for the
  // next rising edge are already stable.
  initial begin
    forever begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        if (rst_n[i] !== 1'b1) begin
          q_clear(i);
          continue;
        end
        chk($sformatf("count_vs_model_i%0d", i), 32'(cnt[i]), 32'(q_size(i)));
        chk($sformatf("count_max_i%0d", i), 32'(cnt[i] <= 5'(dep(i) + 1)), 32'd1);
        if (hold[i]) begin
          chk($sformatf("hold_valid_i%0d", i), 32'(rv[i]), 32'd1);
          chk($sformatf("hold_data_i%0d", i), rd[i], hold_d[i]);
        end
        if (rv[i] && rr[i]) begin
          pops[i]++;
          if (q_size(i) == 0) chk($sformatf("underflow_i%0d", i), 32'(q_size(i)), 32'd1);
          else                chk($sformatf("order_i%0d", i), rd[i], q_pop(i));
        end
        if (wv[i] && wrdy[i]) q_push(i, wd[i]);
        hold[i]   = rv[i] && !rr[i];
        hold_d[i] = rd[i];
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // offer one word and hold it until an edge accepts it
  task automatic push(input int i, input logic [31:0] v);
    int   n;
    logic a;
    wv[i] = 1'b1;
    wd[i] = v;
    n = 0;
    do begin
      a = wrdy[i];
      tick();
      n++;
    end while (!a && n < 50);
    wv[i] = 1'b0;
    chk("push_accept", 32'(a), 32'd1);
  endtask

  task automatic wait_rv(input int i);
    int n;
    n = 0;
    while (!rv[i] && n < 50) begin
      tick();
      n++;
    end
    chk("wait_rd_valid", 32'(rv[i]), 32'd1);
  endtask

  initial begin
    int v, edges, acc_n, cyc;
    logic acc;
    rst_n = 2'b00; wv = '0; rr = '0; wd = '0;
    #7;
    // reset state
    for (int i = 0; i < 2; i++) begin
      chk("reset_wr_ready", 32'(wrdy[i]), 32'd0);
      chk("reset_rd_valid", 32'(rv[i]), 32'd0);
      chk("reset_count", 32'(cnt[i]), 32'd0);
    end
    rst_n = 2'b11;
    tick();
    chk("release_wr_ready_i0", 32'(wrdy[0]), 32'd1);
    chk("release_wr_ready_i1", 32'(wrdy[1]), 32'd1);

    // single word, held for 5 cycles under backpressure
    wv[0] = 1'b1; wd[0] = 32'hA5;
    tick();
    wv[0] = 1'b0;
    chk("single_count_k", 32'(cnt[0]), 32'd1);
    chk("single_rv_k", 32'(rv[0]), 32'd0);
    tick();
    chk("single_rv_k1", 32'(rv[0]), 32'd1);
    chk("single_data", rd[0], 32'hA5);
    chk("single_count_k1", 32'(cnt[0]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("single_hold", rd[0], 32'hA5);
    end
    rr[0] = 1'b1;
    tick();
    rr[0] = 1'b0;
    chk("single_pop_rv", 32'(rv[0]), 32'd0);
    chk("single_pop_count", 32'(cnt[0]), 32'd0);

    // fill to capacity C_DEPTH+1
    for (int k = 1; k <= 5; k++) push(0, 32'(k));
    chk("fill_count", 32'(cnt[0]), 32'd5);
    chk("fill_wr_ready", 32'(wrdy[0]), 32'd0);
    chk("fill_head", rd[0], 32'd1);
    wv[0] = 1'b1; wd[0] = 32'd6;
    tick();
    chk("fill_stall_count", 32'(cnt[0]), 32'd5);
    rr[0] = 1'b1;
    tick();
    rr[0] = 1'b0;
    chk("fill_pop_wr_ready", 32'(wrdy[0]), 32'd1);
    chk("fill_pop_count", 32'(cnt[0]), 32'd4);
    tick();
    wv[0] = 1'b0;
    chk("fill_w6_count", 32'(cnt[0]), 32'd5);
    for (int e = 2; e <= 6; e++) begin
      wait_rv(0);
      chk("fill_drain_order", rd[0], 32'(e));
      rr[0] = 1'b1;
      tick();
      rr[0] = 1'b0;
    end
    chk("fill_empty", 32'(cnt[0]), 32'd0);

    // streaming 20 words through depth 4
    wv[0] = 1'b1; rr[0] = 1'b1; v = 0; wd[0] = 32'd0; edges = 0;
    while ((v < 20 || cnt[0] != 0 || rv[0]) && edges < 60) begin
      acc = wv[0] && wrdy[0];
      tick();
      edges++;
      if (acc) begin
        v++;
        wd[0] = 32'(v);
        if (v == 20) wv[0] = 1'b0;
      end
      if (edges >= 2 && edges <= 20) chk("stream_count", 32'(cnt[0]), 32'd2);
    end
    rr[0] = 1'b0;
    chk("stream_edges", 32'(edges), 32'd22);

    // mid-run asynchronous reset
    push(0, 32'h21); push(0, 32'h22); push(0, 32'h23);
    chk("midrst_count_pre", 32'(cnt[0]), 32'd3);
    #1;
    rst_n[0] = 1'b0;
    q_clear(0);
    #1;
    chk("midrst_rv", 32'(rv[0]), 32'd0);
    chk("midrst_count", 32'(cnt[0]), 32'd0);
    chk("midrst_wr_ready", 32'(wrdy[0]), 32'd0);
    #1;
    rst_n[0] = 1'b1;
    push(0, 32'h11);
    wait_rv(0);
    chk("midrst_first_out", rd[0], 32'h11);
    rr[0] = 1'b1;
    tick();
    rr[0] = 1'b0;

    // random backpressure, depth 8
    acc_n = 0; cyc = 0; pops[1] = 0;
    while (acc_n < 1000 && cyc < 20000) begin
      wv[1] = 1'($urandom);
      wd[1] = $urandom;
      rr[1] = 1'($urandom);
      if (wv[1] && wrdy[1]) acc_n++;
      tick();
      cyc++;
    end
    wv[1] = 1'b0;
    rr[1] = 1'b1;
    cyc = 0;
    while ((cnt[1] != 0 || rv[1]) && cyc < 100) begin
      tick();
      cyc++;
    end
    rr[1] = 1'b0;
    tick();
    chk("rand_accepted", 32'(acc_n), 32'd1000);
    chk("rand_popped", 32'(pops[1]), 32'd1000);
    chk("rand_drained", 32'(cnt[1]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
